// File: rtl/mic_capture_pkg.sv
// Shared types and constants for the I2S mic-array capture block.
// The frame is two 32-bit slots; only the top 16 bits of each 24-bit sample are kept.
package mic_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } cap_state_t;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int KEEP_BITS  = 16;

  typedef struct packed {
    logic [KEEP_BITS-1:0] l;
    logic [KEEP_BITS-1:0] r;
  } pair_sample_t;

  // Slot bits 1..KEEP_BITS carry MSB-first data (bit 0 is the I2S one-BCLK delay).
  function automatic logic keep_bit(input logic [5:0] bit_cnt);
    return (bit_cnt[4:0] >= 5'd1) && (bit_cnt[4:0] <= 5'(KEEP_BITS));
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit-clock and word-select generator. Strobes mark the CLK cycle in which
// BCLK is about to toggle, so sampling happens one cycle before the mic sees the edge.
module i2s_clk_gen #(
  parameter int BCLK_HALF_DIV = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       enable,
  output logic       bclk,
  output logic       ws,
  output logic [5:0] bit_cnt,
  output logic       rise_stb,
  output logic       fall_stb
);

  localparam int DW = $clog2(BCLK_HALF_DIV);

  logic [DW-1:0] div_cnt;
  logic          term;

  assign term     = (div_cnt == DW'(BCLK_HALF_DIV - 1));
  assign rise_stb = term && !bclk;
  assign fall_stb = term && bclk;
  // WS derives from bit_cnt, which only advances on falling edges.
  assign ws       = bit_cnt[5];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (term) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall_stb) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_mic_array_capture.sv
// I2S master capturing one stereo frame from each mic pair into a holding buffer
// that the DMA reads pair by pair; read_ready strobes once per committed frame.
module i2s_mic_array_capture
  import mic_capture_pkg::*;
#(
  parameter int NUM_MIC_PAIRS = 5,
  parameter int BCLK_HALF_DIV = 8,
  parameter int WARMUP_FRAMES = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     enable,
  output logic                     i2s_bclk,
  output logic                     i2s_ws,
  input  logic [NUM_MIC_PAIRS-1:0] i2s_sd,
  input  logic [2:0]               select,
  output logic [31:0]              mic_data,
  output logic                     read_ready,
  output logic [15:0]              frame_count,
  output cap_state_t               state_dbg
);

  logic [5:0]               bit_cnt;
  logic                     rise_stb;
  logic                     fall_stb;
  logic                     keep_stb;
  logic                     frame_end;
  logic [NUM_MIC_PAIRS-1:0] sd_meta;
  logic [NUM_MIC_PAIRS-1:0] sd_sync;
  pair_sample_t             shift_q   [NUM_MIC_PAIRS];
  pair_sample_t             holding_q [NUM_MIC_PAIRS];
  cap_state_t               state;
  logic [7:0]               warm_cnt;

  i2s_clk_gen #(
    .BCLK_HALF_DIV (BCLK_HALF_DIV)
  ) u_clk_gen (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .enable   (enable),
    .bclk     (i2s_bclk),
    .ws       (i2s_ws),
    .bit_cnt  (bit_cnt),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign keep_stb  = rise_stb && keep_bit(bit_cnt);
  assign frame_end = rise_stb && (bit_cnt == 6'(FRAME_BITS - 1));
  assign state_dbg = state;

  // SD lines are asynchronous to CLK.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sd_meta <= '0;
      sd_sync <= '0;
    end else begin
      sd_meta <= i2s_sd;
      sd_sync <= sd_meta;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int p = 0; p < NUM_MIC_PAIRS; p++) begin
        shift_q[p] <= '0;
      end
    end else if (keep_stb) begin
      for (int p = 0; p < NUM_MIC_PAIRS; p++) begin
        if (bit_cnt[5]) begin
          shift_q[p].r <= {shift_q[p].r[KEEP_BITS-2:0], sd_sync[p]};
        end else begin
          shift_q[p].l <= {shift_q[p].l[KEEP_BITS-2:0], sd_sync[p]};
        end
      end
    end
  end

  // A commit in the same cycle that enable falls still completes before going idle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      warm_cnt    <= '0;
      read_ready  <= 1'b0;
      frame_count <= '0;
      for (int p = 0; p < NUM_MIC_PAIRS; p++) begin
        holding_q[p] <= '0;
      end
    end else begin
      read_ready <= 1'b0;
      case (state)
        IDLE: begin
          warm_cnt <= '0;
          if (enable) begin
            state <= (WARMUP_FRAMES == 0) ? RUN : WARMUP;
          end
        end
        WARMUP: begin
          if (!enable) begin
            state <= IDLE;
          end else if (frame_end) begin
            warm_cnt <= warm_cnt + 8'd1;
            if (warm_cnt + 8'd1 == 8'(WARMUP_FRAMES)) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (frame_end) begin
            holding_q   <= shift_q;
            read_ready  <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end
          if (!enable) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mic_data = '0;
    for (int p = 0; p < NUM_MIC_PAIRS; p++) begin
      if (int'(select) == p) begin
        mic_data = holding_q[p];
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_array_capture.sv
// Directed bench for i2s_mic_array_capture: an I2S mic model drives the SD lines,
// a scoreboard tracks the sample words the model actually sent.
module tb_i2s_mic_array_capture;
  import mic_capture_pkg::*;

  localparam int NP = 5;

  // clock / reset
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  logic          enable = 1'b0;
  logic          i2s_bclk;
  logic          i2s_ws;
  logic [NP-1:0] sd_drv = '0;
  logic [2:0]    select = 3'd0;
  logic [31:0]   mic_data;
  logic          read_ready;
  logic [15:0]   frame_count;
  cap_state_t    state_dbg;

  i2s_mic_array_capture #(
    .NUM_MIC_PAIRS (NP),
    .BCLK_HALF_DIV (8),
    .WARMUP_FRAMES (2)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .enable      (enable),
    .i2s_bclk    (i2s_bclk),
    .i2s_ws      (i2s_ws),
    .i2s_sd      (sd_drv),
    .select      (select),
    .mic_data    (mic_data),
    .read_ready  (read_ready),
    .frame_count (frame_count),
    .state_dbg   (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // I2S mic model: data changes after BCLK falls, MSB one BCLK after each WS edge
  logic [23:0] mdl_l [NP];
  logic [23:0] mdl_r [NP];
  logic [23:0] cur_l [NP];
  logic [23:0] cur_r [NP];
  logic [23:0] m_w;
  int          m_idx = 0;
  logic        m_last_ws = 1'b0;
  bit          vary = 1'b0;
  logic [31:0] exp_q[$];

  task automatic model_init();
    m_idx = 0;
    m_last_ws = 1'b0;
    for (int p = 0; p < NP; p++) begin
      cur_l[p] = mdl_l[p];
      cur_r[p] = mdl_r[p];
    end
  endtask

  always begin
    @(negedge i2s_bclk);
    #1;
    if (RESET_N && enable) begin
      if (i2s_ws !== m_last_ws) begin
        m_idx = 0;
        m_last_ws = i2s_ws;
        if (!i2s_ws) begin
          if (vary) begin
            mdl_l[0] = mdl_l[0] + 24'h111111;
            mdl_r[0] = mdl_r[0] - 24'h010101;
          end
          for (int p = 0; p < NP; p++) begin
            cur_l[p] = mdl_l[p];
            cur_r[p] = mdl_r[p];
          end
        end
      end else begin
        m_idx++;
      end
      if (i2s_ws && m_idx == 17) exp_q.push_back({cur_l[0][23:8], cur_r[0][23:8]});
      for (int p = 0; p < NP; p++) begin
        m_w = i2s_ws ? cur_r[p] : cur_l[p];
        sd_drv[p] = (m_idx >= 1 && m_idx <= 24) ? m_w[24-m_idx] : 1'b0;
      end
    end
  end

  // driver tasks
  task automatic start_run();
    @(posedge CLK);
    #1;
    model_init();
    enable = 1'b1;
  endtask

  // first negedge seen is index 0
  task automatic wait_pulse(input int max_cyc, output int n, output bit ok);
    ok = 1'b0;
    n = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (read_ready === 1'b1) begin
        n = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure_clocks(input int cycles);
    int last_rise = -1;
    int first_rise = -1;
    int period = 0;
    int bad_period = 0;
    int ws_rise_at = -1;
    int ws_fall_at = -1;
    int hi_len = -1;
    int lo_len = -1;
    int ws_bad = 0;
    logic pb = 1'b0;
    logic pw = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (i2s_bclk && !pb) begin
        if (first_rise < 0) first_rise = i;
        if (last_rise >= 0) begin
          period = i - last_rise;
          if (period != 16) bad_period++;
        end
        last_rise = i;
      end
      if (i2s_ws !== pw) begin
        if (!(pb && !i2s_bclk)) ws_bad++;
        if (i2s_ws) begin
          if (ws_fall_at >= 0) lo_len = i - ws_fall_at;
          ws_rise_at = i;
        end else begin
          if (ws_rise_at >= 0) hi_len = i - ws_rise_at;
          ws_fall_at = i;
        end
      end
      pb = i2s_bclk;
      pw = i2s_ws;
    end
    chk("bclk_first_rise", first_rise, 32'd8);
    chk("bclk_period", period, 32'd16);
    chk("bclk_period_bad", bad_period, 32'd0);
    chk("ws_high_len", hi_len, 32'd512);
    chk("ws_low_len", lo_len, 32'd512);
    chk("ws_edge_not_on_bclk_fall", ws_bad, 32'd0);
  endtask

  int          pn;
  bit          pok;
  logic [31:0] last_exp = '0;

  // scoreboard: mic_data only moves in read_ready cycles and matches the model
  task automatic run_stable(input int pulses);
    int seen = 0;
    int glitch = 0;
    logic [31:0] prev = mic_data;
    logic [31:0] e;
    for (int i = 0; i < 1100 * pulses && seen < pulses; i++) begin
      @(negedge CLK);
      if (read_ready === 1'b1) begin
        seen++;
        e = (exp_q.size() > 0) ? exp_q[$] : 32'h0;
        chk("stable_value", mic_data, e);
        chk("stable_changed", 32'(mic_data != prev), 32'd1);
        chk("stable_frame_count", 32'(frame_count), 32'(3 + seen));
        last_exp = e;
      end else if (mic_data !== prev) begin
        glitch++;
      end
      prev = mic_data;
    end
    chk("stable_pulses", seen, pulses);
    chk("stable_glitches", glitch, 32'd0);
  endtask

  task automatic wait_abort_point(output bit ok);
    bit seen_ws = 1'b0;
    int falls = 0;
    logic pb = i2s_bclk;
    logic pw = i2s_ws;
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge CLK);
      if (!seen_ws && i2s_ws && !pw) begin
        seen_ws = 1'b1;
      end else if (seen_ws && pb && !i2s_bclk) begin
        falls++;
        if (falls == 8) begin
          ok = 1'b1;
          break;
        end
      end
      pb = i2s_bclk;
      pw = i2s_ws;
    end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      mdl_l[p] = 24'h0;
      mdl_r[p] = 24'h0;
    end
    mdl_l[0] = 24'h123456; mdl_r[0] = 24'hABCDEF;
    mdl_l[2] = 24'hFFFFFF; mdl_r[2] = 24'h000000;
    mdl_l[4] = 24'h800000; mdl_r[4] = 24'h7FFFFF;
    model_init();

    // reset state
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    @(negedge CLK);
    chk("rst_bclk", 32'(i2s_bclk), 32'd0);
    chk("rst_ws", 32'(i2s_ws), 32'd0);
    chk("rst_read_ready", 32'(read_ready), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_mic_data", mic_data, 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));

    // warmup, clocking, first commit
    start_run();
    fork
      wait_pulse(4000, pn, pok);
      measure_clocks(2200);
    join
    chk("first_pulse_seen", 32'(pok), 32'd1);
    chk("first_pulse_latency", pn, 32'd3064);
    chk("frame_count_1", 32'(frame_count), 32'd1);
    @(negedge CLK);
    chk("pulse_width", 32'(read_ready), 32'd0);
    select = 3'd0; #1 chk("data_sel0", mic_data, 32'h1234ABCD);
    select = 3'd4; #1 chk("data_sel4", mic_data, 32'h80007FFF);
    select = 3'd6; #1 chk("data_sel6", mic_data, 32'h0);
    select = 3'd2; #1 chk("data_sel2", mic_data, 32'hFFFF0000);
    select = 3'd5;
    wait_pulse(1100, pn, pok);
    chk("sel5_out_of_range", mic_data, 32'h0);
    select = 3'd0;
    chk("interval_2", pn + 2, 32'd1024);
    chk("frame_count_2", 32'(frame_count), 32'd2);
    wait_pulse(1100, pn, pok);
    chk("interval_3", pn + 1, 32'd1024);
    chk("frame_count_3", 32'(frame_count), 32'd3);
    chk("data_sel0_f3", mic_data, 32'h1234ABCD);

    // stability with samples changing every frame
    vary = 1'b1;
    run_stable(2);

    // abort at bit_cnt 40
    wait_abort_point(pok);
    chk("abort_point", 32'(pok), 32'd1);
    @(posedge CLK);
    #1 enable = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_bclk", 32'(i2s_bclk), 32'd0);
    chk("abort_ws", 32'(i2s_ws), 32'd0);
    chk("abort_state", 32'(state_dbg), 32'(IDLE));
    wait_pulse(2000, pn, pok);
    chk("abort_no_pulse", 32'(pok), 32'd0);
    chk("abort_holding", mic_data, last_exp);
    chk("abort_frame_count", 32'(frame_count), 32'd5);

    // re-enable: warmup frames discarded again
    start_run();
    wait_pulse(4000, pn, pok);
    chk("restart_latency", pn, 32'd3064);
    chk("restart_frame_count", 32'(frame_count), 32'd6);
    chk("restart_data", mic_data, (exp_q.size() > 0) ? exp_q[$] : 32'h0);

    // asynchronous reset between clock edges
    repeat (100) @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_frame_count", 32'(frame_count), 32'd0);
    chk("arst_mic_data", mic_data, 32'd0);
    chk("arst_bclk", 32'(i2s_bclk), 32'd0);
    chk("arst_read_ready", 32'(read_ready), 32'd0);
    chk("arst_state", 32'(state_dbg), 32'(IDLE));
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    model_init();
    fork
      wait_pulse(4000, pn, pok);
      begin
        @(negedge CLK);
        @(negedge CLK);
        chk("arst_restart_state", 32'(state_dbg), 32'(WARMUP));
      end
    join
    chk("arst_latency", pn, 32'd3064);
    chk("arst_frame_count_1", 32'(frame_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
